// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO plus launch sequencer for the UART transmitter.
// Bytes written on wr_en are queued in a circular buffer. They are then handed to the
// transmitter one at a time through the tx_start/tx_din/tx_done handshake.
module uart_tx_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                         tx_clk,
    input  logic                         tx_rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         busy,
    output logic                         tx_start,
    output logic [DATA_WIDTH-1:0]        tx_din,
    input  logic                         tx_done
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StWaitLow
    } state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] tx_din_q, tx_din_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic push;
    logic pop;

    // Flags are decoded from the registered count, so a pop never frees space in its own cycle
    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_start = (state_q == StStart);
    assign tx_din   = tx_din_q;
    assign busy     = (state_q != StIdle) || !empty;

    assign push = wr_en && !full;

    // Launch sequencer next state; the pop happens on the IDLE -> START transition
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                // A stretched done level must drop before the next byte can launch
                if (!tx_done) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Pointer, occupancy, output byte and overflow next-state
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tx_din_d   = tx_din_q;
        overflow_d = wr_en && full;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            tx_din_d = mem[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tx_din_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tx_din_q   <= tx_din_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge tx_clk) begin
        if (!tx_rst && push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based byte model plus a transmitter model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          tx_clk = 1'b0;
    logic          tx_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full, empty, overflow, busy, tx_start;
    logic [CW-1:0] count;
    logic [DW-1:0] tx_din;
    logic          tx_done = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // Transmitter model knobs (written by tests, read by the monitor)
    int tx_delay = 2;
    int tx_hold  = 1;
    bit tx_stall = 1'b0;

    // Reference model state (written only by the monitor)
    logic [DW-1:0] exp_q[$];
    int            mcount = 0;
    logic [DW-1:0] last_din = '0;
    bit            flight = 1'b0;
    bit            drop_next = 1'b0;
    bit            prev_start = 1'b0;
    int            launches = 0;
    int            txm_phase = 0;
    int            txm_wait = 0;
    int            txm_hold = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .tx_clk  (tx_clk),
        .tx_rst  (tx_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .busy    (busy),
        .tx_start(tx_start),
        .tx_din  (tx_din),
        .tx_done (tx_done)
    );

    always #5 tx_clk = ~tx_clk;

    // Monitor: updates the byte-queue model after each edge, checks outputs, drives tx_done
    always @(posedge tx_clk) begin
        #1;
        if (tx_rst) begin
            exp_q.delete();
            mcount    = 0;
            last_din  = '0;
            flight    = 1'b0;
            drop_next = 1'b0;
            txm_phase = 0;
            tx_done   = 1'b0;
            n_total++;
            if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0 ||
                tx_start !== 1'b0 || overflow !== 1'b0 || tx_din !== '0)
                $display("FAIL reset_values: count=%0d empty=%b full=%b busy=%b start=%b ovf=%b din=%h, need 0 1 0 0 0 0 00",
                         count, empty, full, busy, tx_start, overflow, tx_din);
            else n_pass++;
        end else begin
            bit exp_ovf;
            if (drop_next) begin
                flight    = 1'b0;
                drop_next = 1'b0;
            end
            exp_ovf = wr_en && (mcount == DEPTH);
            if (wr_en && mcount != DEPTH) begin
                exp_q.push_back(wr_data);
                mcount++;
            end
            if (tx_start) begin
                launches++;
                n_total++;
                if (prev_start || txm_phase != 0 || exp_q.size() == 0) begin
                    $display("FAIL launch_legal: prev_start=%b txm_phase=%0d queued=%0d, need 0 0 >0",
                             prev_start, txm_phase, exp_q.size());
                end else begin
                    n_pass++;
                    n_total++;
                    if (tx_din !== exp_q[0])
                        $display("FAIL launch_byte: tx_din=%h, need %h", tx_din, exp_q[0]);
                    else n_pass++;
                    last_din = exp_q[0];
                    void'(exp_q.pop_front());
                    mcount--;
                end
                flight    = 1'b1;
                txm_phase = 1;
                txm_wait  = tx_delay;
            end else begin
                n_total++;
                if (tx_din !== last_din) $display("FAIL din_stable: tx_din=%h, need %h", tx_din, last_din);
                else n_pass++;
                // Transmitter model: wait tx_delay cycles, then hold tx_done high tx_hold cycles
                if (txm_phase == 1 && !tx_stall) begin
                    if (txm_wait <= 1) begin
                        tx_done   = 1'b1;
                        txm_hold  = tx_hold;
                        txm_phase = 2;
                    end else begin
                        txm_wait--;
                    end
                end else if (txm_phase == 2) begin
                    if (txm_hold <= 1) begin
                        tx_done   = 1'b0;
                        txm_phase = 0;
                        drop_next = 1'b1;
                    end else begin
                        txm_hold--;
                    end
                end
            end
            n_total++;
            if (count !== CW'(mcount) || full !== (mcount == DEPTH) || empty !== (mcount == 0) ||
                overflow !== exp_ovf || busy !== (flight || mcount > 0))
                $display("FAIL status: count=%0d full=%b empty=%b ovf=%b busy=%b, need %0d %b %b %b %b",
                         count, full, empty, overflow, busy, mcount, (mcount == DEPTH), (mcount == 0),
                         exp_ovf, (flight || mcount > 0));
            else n_pass++;
        end
        prev_start = tx_start;
    end

    task automatic wait_drain(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge tx_clk);
            #2;
            if (exp_q.size() == 0 && mcount == 0 && txm_phase == 0 && !flight && !drop_next) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge tx_clk);
        tx_rst = 1'b1;
        repeat (2) @(negedge tx_clk);
        n_total++;
        if (count !== '0 || empty !== 1'b1 || busy !== 1'b0 || tx_din !== '0)
            $display("FAIL test_reset: count=%0d empty=%b busy=%b din=%h, need 0 1 0 00",
                     count, empty, busy, tx_din);
        else n_pass++;
        tx_rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        tx_delay = 2;
        tx_hold  = 1;
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (tx_start !== 1'b0) $display("FAIL single_k: tx_start=%b, need 0", tx_start);
        else n_pass++;
        @(negedge tx_clk);
        wr_en = 1'b0;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (tx_start !== 1'b1 || tx_din !== 8'hA5)
            $display("FAIL single_k1: tx_start=%b tx_din=%h, need 1 a5", tx_start, tx_din);
        else n_pass++;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (tx_start !== 1'b0) $display("FAIL single_k2: tx_start=%b, need 0", tx_start);
        else n_pass++;
        wait_drain(200, ok);
        n_total++;
        if (!ok || empty !== 1'b1 || busy !== 1'b0)
            $display("FAIL single_idle: drained=%b empty=%b busy=%b, need 1 1 0", ok, empty, busy);
        else n_pass++;
    endtask

    task automatic test_burst();
        bit ok;
        int start_l;
        logic [DW-1:0] pat [4];
        pat[0] = 8'hA5; pat[1] = 8'hA8; pat[2] = 8'hAB; pat[3] = 8'hAE;
        tx_delay = 320;
        tx_hold  = 1;
        start_l  = launches;
        for (int i = 0; i < 4; i++) begin
            @(negedge tx_clk);
            wr_en   = 1'b1;
            wr_data = pat[i];
        end
        @(negedge tx_clk);
        wr_en = 1'b0;
        wait_drain(2000, ok);
        n_total++;
        if (!ok || launches - start_l != 4)
            $display("FAIL burst_launches: drained=%b launches=%0d, need 1 4", ok, launches - start_l);
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        int start_l;
        tx_delay = 2;
        tx_hold  = 1;
        tx_stall = 1'b1;
        start_l  = launches;
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge tx_clk);
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
        end
        @(negedge tx_clk);
        wr_en = 1'b0;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (count !== CW'(DEPTH) || full !== 1'b1)
            $display("FAIL ovf_full: count=%0d full=%b, need %0d 1", count, full, DEPTH);
        else n_pass++;
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        @(posedge tx_clk);
        #2;
        n_total++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH))
            $display("FAIL ovf_pulse: overflow=%b count=%0d, need 1 %0d", overflow, count, DEPTH);
        else n_pass++;
        @(negedge tx_clk);
        wr_en = 1'b0;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_end: overflow=%b, need 0", overflow);
        else n_pass++;
        tx_stall = 1'b0;
        wait_drain(3000, ok);
        n_total++;
        if (!ok || launches - start_l != DEPTH + 1)
            $display("FAIL ovf_drain: drained=%b launches=%0d, need 1 %0d", ok, launches - start_l, DEPTH + 1);
        else n_pass++;
    endtask

    task automatic test_long_done();
        bit ok;
        int start_l;
        tx_delay = 3;
        tx_hold  = 5;
        start_l  = launches;
        for (int i = 0; i < 2; i++) begin
            @(negedge tx_clk);
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
        end
        @(negedge tx_clk);
        wr_en = 1'b0;
        wait_drain(500, ok);
        n_total++;
        if (!ok || launches - start_l != 2)
            $display("FAIL long_done: drained=%b launches=%0d, need 1 2", ok, launches - start_l);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        tx_delay = 2;
        tx_hold  = 1;
        tx_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge tx_clk);
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
        end
        @(negedge tx_clk);
        wr_en = 1'b0;
        repeat (3) @(posedge tx_clk);
        #2;
        n_total++;
        if (count !== CW'(3) || busy !== 1'b1)
            $display("FAIL rstmid_pre: count=%0d busy=%b, need 3 1", count, busy);
        else n_pass++;
        @(negedge tx_clk);
        tx_rst = 1'b1;
        @(posedge tx_clk);
        #2;
        n_total++;
        if (count !== '0 || empty !== 1'b1 || tx_din !== '0 || tx_start !== 1'b0)
            $display("FAIL rstmid_post: count=%0d empty=%b din=%h start=%b, need 0 1 00 0",
                     count, empty, tx_din, tx_start);
        else n_pass++;
        @(negedge tx_clk);
        tx_rst   = 1'b0;
        tx_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge tx_clk);
            #2;
            n_total++;
            if (tx_start !== 1'b0) $display("FAIL rstmid_quiet: tx_start=%b cycle=%0d, need 0", tx_start, i);
            else n_pass++;
        end
        @(negedge tx_clk);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        @(negedge tx_clk);
        wr_en = 1'b0;
        wait_drain(200, ok);
        n_total++;
        if (!ok) $display("FAIL rstmid_recover: drained=%b, need 1", ok);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int start_l;
        start_l  = launches;
        tx_delay = int'($urandom_range(1, 4));
        tx_hold  = int'($urandom_range(1, 2));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            @(negedge tx_clk);
            while (mcount >= DEPTH) begin
                wr_en = 1'b0;
                @(negedge tx_clk);
            end
            wr_en   = 1'b1;
            wr_data = DW'(i);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge tx_clk);
                wr_en = 1'b0;
            end
        end
        @(negedge tx_clk);
        wr_en = 1'b0;
        wait_drain(3000, ok);
        n_total++;
        if (!ok || launches - start_l != 3 * DEPTH)
            $display("FAIL wrap_launches: drained=%b launches=%0d, need 1 %0d", ok, launches - start_l, 3 * DEPTH);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_long_done();
        test_reset_mid();
        test_wrap();
        repeat (2) @(posedge tx_clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, need completion");
        $fatal(1, "timeout");
    end

endmodule
